// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, TX control state encoding and strobe bundle.
// Used by the TX control unit today and intended for the RX side as well.
package uart_pkg;

    localparam int UART_WORD_SIZE    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SENDING = 2'd2
    } uart_state_e;

    typedef struct packed {
        logic load_shftreg;
        logic start;
        logic shift;
        logic clear;
        logic tx_done;
    } tx_strobe_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period with tick, wrapping back to 0 after it.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == TERM);
    assign tick    = enable && !clear && at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_control_unit.sv
// UART transmit controller: sequences the TX datapath through load, start bit,
// data/stop shifting and frame completion using a per-bit baud counter.
module uart_tx_control_unit
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = UART_WORD_SIZE,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic LOAD_XMT_DATAREG,
    input  logic BYTE_READY,
    input  logic T_BYTE,
    input  logic BC_LT_BCMAX,
    output logic LOAD_XMT_DR,
    output logic LOAD_XMT_SHFTREG,
    output logic START,
    output logic SHIFT,
    output logic CLEAR,
    output logic BUSY,
    output logic TX_DONE
);

    if (WORD_SIZE < 1 || CLKS_PER_BIT < 2) begin : g_bad_param
        $error("uart_tx_control_unit: WORD_SIZE must be >= 1 and CLKS_PER_BIT >= 2");
    end

    uart_state_e state_q, state_d;
    tx_strobe_t  strb;
    logic        baud_clr;
    logic        baud_en;
    logic        baud_tick;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .gclk   (CLOCK),
        .grst_n (RESET),
        .clear  (baud_clr),
        .enable (baud_en),
        .tick   (baud_tick)
    );

    always_comb begin
        state_d  = state_q;
        strb     = '0;
        baud_clr = 1'b1;
        baud_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (BYTE_READY) begin
                    strb.load_shftreg = 1'b1;
                    state_d           = WAITING;
                end
            end
            WAITING: begin
                if (T_BYTE) begin
                    strb.start = 1'b1;
                    state_d    = SENDING;
                end
            end
            SENDING: begin
                baud_clr = 1'b0;
                baud_en  = 1'b1;
                if (baud_tick) begin
                    if (BC_LT_BCMAX) begin
                        strb.shift = 1'b1;
                    end else begin
                        strb.clear   = 1'b1;
                        strb.tx_done = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobes must stay quiet for the whole time reset is held, not just after the edge.
        if (!RESET) begin
            strb = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Host data-register loads pass straight through so it can refill during a frame.
    assign LOAD_XMT_DR      = LOAD_XMT_DATAREG;
    assign LOAD_XMT_SHFTREG = strb.load_shftreg;
    assign START            = strb.start;
    assign SHIFT            = strb.shift;
    assign CLEAR            = strb.clear;
    assign TX_DONE          = strb.tx_done;
    assign BUSY             = (state_q != IDLE);

endmodule
